nn_scan: RTL and testbench

// - Nearest-neighbour search for the RRT tree: scans nodes 0..node_count-1 in the node BRAM, returns index/coords of the node closest to a query point.
// - Sits directly downstream of the node bram; drives its address and consumes read_data (1-cycle registered read latency); never writes it.
// - The extend stage consumes the result; the sampler supplies the query.

---
 rtl/rrt_pkg.sv | 37 +++
 rtl/dist_sq_unit.sv | 50 +++++
 rtl/nn_scan.sv | 165 ++++++++++++++++
 tb/tb_nn_scan.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rrt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rrt_pkg
// Brief    : Shared RRT types, widths, nn_scan state encodings and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package rrt_pkg;

    localparam int c_COORD_WIDTH = 16;
    localparam int c_DIST_WIDTH  = 2*c_COORD_WIDTH + 3;

    typedef logic signed [c_COORD_WIDTH-1:0] coord_t;
    typedef struct packed {
        coord_t y;
        coord_t x;
    } point_t;
    typedef logic [c_DIST_WIDTH-1:0] dist_t;

    localparam int                c_ST_W     = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_SCAN  = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_DRAIN = 2'd2;
    localparam logic [c_ST_W-1:0] c_ST_DONE  = 2'd3;

    function automatic point_t to_point(input coord_t x, input coord_t y);
        point_t p;
        p.x = x;
        p.y = y;
        return p;
    endfunction

    function automatic point_t from_word(input logic [2*c_COORD_WIDTH-1:0] w);
        return point_t'(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dist_sq_unit.sv
`default_nettype none
// ============================================================================
// Module   : dist_sq_unit
// Brief    : Registered squared Euclidean distance between two {y,x} points.
// Revision : 1.0 - initial release
// ============================================================================
module dist_sq_unit
    import rrt_pkg::*;
#(
    parameter int COORD_WIDTH = c_COORD_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*COORD_WIDTH-1:0] i_node,
    input  logic [2*COORD_WIDTH-1:0] i_query,
    output logic [2*COORD_WIDTH+2:0] o_dist
);

    localparam int c_CW = COORD_WIDTH;
    localparam int c_SW = 2*COORD_WIDTH + 2;

    logic [c_CW:0]   w_dx;
    logic [c_CW:0]   w_dy;
    logic [c_SW-1:0] w_dx_ext;
    logic [c_SW-1:0] w_dy_ext;
    logic [c_SW-1:0] w_sq_x;
    logic [c_SW-1:0] w_sq_y;

    // One extra bit makes the difference exact for any pair of coordinates.
    assign w_dx = {i_node[c_CW-1], i_node[c_CW-1:0]}
                - {i_query[c_CW-1], i_query[c_CW-1:0]};
    assign w_dy = {i_node[2*c_CW-1], i_node[2*c_CW-1:c_CW]}
                - {i_query[2*c_CW-1], i_query[2*c_CW-1:c_CW]};

    // Sign-extended modular product equals the true square, which always fits.
    assign w_dx_ext = {{(c_SW-c_CW-1){w_dx[c_CW]}}, w_dx};
    assign w_dy_ext = {{(c_SW-c_CW-1){w_dy[c_CW]}}, w_dy};
    assign w_sq_x   = w_dx_ext * w_dx_ext;
    assign w_sq_y   = w_dy_ext * w_dy_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_dist <= '0;
        end else begin
            o_dist <= {1'b0, w_sq_x} + {1'b0, w_sq_y};
        end
    end

endmodule
`default_nettype wire

// File: rtl/nn_scan.sv
`default_nettype none
// ============================================================================
// Module   : nn_scan
// Brief    : Nearest-neighbour scan over the RRT node BRAM for one query point.
//            Optional NN_SCAN_MAXDIST_EN adds a max_dist_sq eligibility limit.
// Revision : 1.0 - initial release
// ============================================================================
module nn_scan
    import rrt_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int COORD_WIDTH = c_COORD_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [COORD_WIDTH-1:0]   query_x,
    input  logic [COORD_WIDTH-1:0]   query_y,
    input  logic [ADDR_WIDTH:0]      node_count,
`ifdef NN_SCAN_MAXDIST_EN
    input  logic [2*COORD_WIDTH+2:0] max_dist_sq,
`endif
    output logic [ADDR_WIDTH-1:0]    mem_address,
    output logic                     mem_write_enable,
    input  logic [2*COORD_WIDTH-1:0] mem_read_data,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic                     result_found,
    output logic [ADDR_WIDTH-1:0]    result_index,
    output logic [COORD_WIDTH-1:0]   result_x,
    output logic [COORD_WIDTH-1:0]   result_y
);

    localparam int c_DW = 2*COORD_WIDTH + 3;

    logic [c_ST_W-1:0]        r_state;
    logic [c_ST_W-1:0]        w_state_next;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_eligible;
    logic                     w_better;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [ADDR_WIDTH-1:0]    r_last;
    logic [2*COORD_WIDTH-1:0] r_query;
    logic                     r_rd_valid;
    logic [ADDR_WIDTH-1:0]    r_idx1;
    logic                     r_dist_valid;
    logic [ADDR_WIDTH-1:0]    r_idx2;
    logic [2*COORD_WIDTH-1:0] r_node2;
    logic [c_DW-1:0]          w_dist;
    logic [c_DW-1:0]          r_best_dist;
    logic                     r_found;
    logic [ADDR_WIDTH-1:0]    r_best_idx;
    logic [2*COORD_WIDTH-1:0] r_best_node;

    assign w_accept = start_valid && (r_state == c_ST_IDLE);
    assign w_last   = (r_addr == r_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DRAIN ends once the last read word has left the BRAM stage.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept) w_state_next = (node_count == '0) ? c_ST_DONE : c_ST_SCAN;
            c_ST_SCAN:  if (w_last) w_state_next = c_ST_DRAIN;
            c_ST_DRAIN: if (!r_rd_valid) w_state_next = c_ST_DONE;
            c_ST_DONE:  if (result_ready) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    dist_sq_unit #(
        .COORD_WIDTH (COORD_WIDTH)
    ) u_dist (
        .clk     (clk),
        .rst     (rst),
        .i_node  (mem_read_data),
        .i_query (r_query),
        .o_dist  (w_dist)
    );

`ifdef NN_SCAN_MAXDIST_EN
    logic [c_DW-1:0] r_max_dist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max_dist <= '0;
        end else if (w_accept) begin
            r_max_dist <= max_dist_sq;
        end
    end

    assign w_eligible = (w_dist < r_max_dist);
`else
    assign w_eligible = 1'b1;
`endif

    assign w_better = w_eligible && (!r_found || (w_dist < r_best_dist));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_last       <= '0;
            r_query      <= '0;
            r_rd_valid   <= 1'b0;
            r_idx1       <= '0;
            r_dist_valid <= 1'b0;
            r_idx2       <= '0;
            r_node2      <= '0;
            r_best_dist  <= '0;
            r_found      <= 1'b0;
            r_best_idx   <= '0;
            r_best_node  <= '0;
        end else begin
            r_rd_valid   <= (r_state == c_ST_SCAN);
            r_idx1       <= r_addr;
            r_dist_valid <= r_rd_valid;
            r_idx2       <= r_idx1;
            r_node2      <= mem_read_data;
            if (w_accept) begin
                r_addr <= '0;
                // Counts above 2**ADDR_WIDTH clamp to a full-table scan.
                if (node_count[ADDR_WIDTH]) begin
                    r_last <= '1;
                end else begin
                    r_last <= node_count[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                end
                r_query     <= {query_y, query_x};
                r_found     <= 1'b0;
                r_best_idx  <= '0;
                r_best_node <= '0;
                r_best_dist <= '0;
            end else begin
                if ((r_state == c_ST_SCAN) && !w_last) begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
                if (r_dist_valid && w_better) begin
                    r_found     <= 1'b1;
                    r_best_dist <= w_dist;
                    r_best_idx  <= r_idx2;
                    r_best_node <= r_node2;
                end
            end
        end
    end

    assign start_ready      = (r_state == c_ST_IDLE);
    assign result_valid     = (r_state == c_ST_DONE);
    assign result_found     = r_found;
    assign result_index     = r_best_idx;
    assign result_x         = r_best_node[COORD_WIDTH-1:0];
    assign result_y         = r_best_node[2*COORD_WIDTH-1:COORD_WIDTH];
    assign mem_address      = r_addr;
    assign mem_write_enable = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_nn_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_scan
// Brief    : Directed self-checking bench for nn_scan with a BRAM model and a
//            plain-arithmetic nearest-neighbour reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_scan;

    localparam int AW = 10;
    localparam int CW = 16;
    localparam int DW = 2*CW + 3;

    logic          clk          = 1'b0;
    logic          rst          = 1'b1;
    logic          start_valid  = 1'b0;
    logic          result_ready = 1'b0;
    logic [CW-1:0] query_x      = '0;
    logic [CW-1:0] query_y      = '0;
    logic [AW:0]   node_count   = '0;
`ifdef NN_SCAN_MAXDIST_EN
    logic [DW-1:0] max_dist_sq  = '0;
`endif
    logic            start_ready;
    logic [AW-1:0]   mem_address;
    logic            mem_write_enable;
    logic [2*CW-1:0] mem_read_data;
    logic            result_valid;
    logic            result_found;
    logic [AW-1:0]   result_index;
    logic [CW-1:0]   result_x;
    logic [CW-1:0]   result_y;

    logic [2*CW-1:0] mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_armed = 1'b0;
    int exp_found, exp_idx, exp_x, exp_y;
    int got_lat, got_found, got_idx, got_x, got_y;

    nn_scan dut (
        .clk              (clk),
        .rst              (rst),
        .start_valid      (start_valid),
        .start_ready      (start_ready),
        .query_x          (query_x),
        .query_y          (query_y),
        .node_count       (node_count),
`ifdef NN_SCAN_MAXDIST_EN
        .max_dist_sq      (max_dist_sq),
`endif
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_found     (result_found),
        .result_index     (result_index),
        .result_x         (result_x),
        .result_y         (result_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_read_data <= mem[mem_address];

    task automatic check(input string name, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_armed && result_valid) begin
            check("res_found", longint'(result_found), exp_found);
            check("res_index", longint'(result_index), exp_idx);
            check("res_x", longint'($signed(result_x)), exp_x);
            check("res_y", longint'($signed(result_y)), exp_y);
            check("busy_start_ready", longint'(start_ready), 0);
            check("write_enable", longint'(mem_write_enable), 0);
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask

    task automatic set_node(input int i, input int x, input int y);
        mem[i] = {16'(y), 16'(x)};
    endtask

    // Reference: brute-force minimum, strictly-less update keeps the lower index.
    task automatic model(input int neff, input int qx, input int qy, input longint maxd);
        longint best, d, dx, dy;
        int nx, ny;
        best = 0;
        exp_found = 0; exp_idx = 0; exp_x = 0; exp_y = 0;
        for (int i = 0; i < neff; i++) begin
            nx = int'($signed(mem[i][15:0]));
            ny = int'($signed(mem[i][31:16]));
            dx = longint'(nx) - longint'(qx);
            dy = longint'(ny) - longint'(qy);
            d  = dx*dx + dy*dy;
            if ((maxd < 0 || d < maxd) && (exp_found == 0 || d < best)) begin
                best = d; exp_found = 1; exp_idx = i; exp_x = nx; exp_y = ny;
            end
        end
    endtask

    task automatic run(input int n, input int qx, input int qy, input int hold,
                       input bit noisy, input longint maxd);
        int neff, c;
        bit done;
        neff = (n > 1024) ? 1024 : n;
        model(neff, qx, qy, maxd);
        @(negedge clk);
        check("accept_start_ready", longint'(start_ready), 1);
        start_valid = 1'b1;
        query_x     = 16'(qx);
        query_y     = 16'(qy);
        node_count  = 11'(n);
`ifdef NN_SCAN_MAXDIST_EN
        max_dist_sq = (maxd < 0) ? '1 : DW'(maxd);
`endif
        @(posedge clk); #1;
        if (noisy) begin
            query_x = 16'h7abc; query_y = 16'h8123; node_count = 11'd5;
        end else begin
            start_valid = 1'b0;
        end
        exp_armed = 1'b1;
        c = 1;
        done = 1'b0;
        for (int k = 0; k < neff + 20 && !done; k++) begin
            @(negedge clk);
            if (c <= neff) check("scan_addr", longint'(mem_address), c - 1);
            if (neff == 0 && c == 1) check("no_scan_addr", longint'(mem_address), 0);
            if (result_valid) done = 1'b1;
            else begin
                @(posedge clk);
                c++;
            end
        end
        if (!done) check("result_timeout_cycle", c, (neff == 0) ? 1 : neff + 3);
        got_lat   = c;
        got_found = int'(result_found);
        got_idx   = int'(result_index);
        got_x     = int'($signed(result_x));
        got_y     = int'($signed(result_y));
        check("latency", got_lat, (neff == 0) ? 1 : neff + 3);
        repeat (hold) @(negedge clk);
        start_valid  = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        exp_armed    = 1'b0;
        check("valid_after_handshake", longint'(result_valid), 0);
        check("ready_after_handshake", longint'(start_ready), 1);
    endtask

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_valid", longint'(result_valid), 0);
        check("rst_found", longint'(result_found), 0);
        check("rst_index", longint'(result_index), 0);
        check("rst_xy", longint'({result_y, result_x}), 0);
        check("rst_addr", longint'(mem_address), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_start_ready", longint'(start_ready), 1);
        check("rst_we", longint'(mem_write_enable), 0);

        // Single node
        clear_mem(); set_node(0, 3, 4);
        run(1, 0, 0, 0, 1'b0, -1);
        check("t1_lat", got_lat, 4); check("t1_idx", got_idx, 0);
        check("t1_x", got_x, 3); check("t1_y", got_y, 4); check("t1_found", got_found, 1);

        // Tie keeps lower index
        clear_mem();
        set_node(0, 10, 10); set_node(1, -2, 1); set_node(2, 5, 5); set_node(3, -2, 1);
        run(4, 0, 0, 2, 1'b0, -1);
        check("t2_lat", got_lat, 7); check("t2_idx", got_idx, 1);
        check("t2_x", got_x, -2); check("t2_y", got_y, 1);

        // Empty tree
        run(0, 0, 0, 0, 1'b0, -1);
        check("t3_lat", got_lat, 1); check("t3_found", got_found, 0); check("t3_idx", got_idx, 0);

        // Coordinate extremes: any wrap of dx or of the sum flips the answer
        clear_mem(); set_node(0, -32768, -32768); set_node(1, 32767, -32768);
        run(2, 32767, 32767, 0, 1'b0, -1);
        check("t4_idx", got_idx, 1); check("t4_x", got_x, 32767); check("t4_y", got_y, -32768);

        // Held result with ignored start_valid, then a back-to-back query
        clear_mem();
        for (int i = 0; i < 6; i++) set_node(i, 3*i - 7, 11 - 2*i);
        run(6, 1, 2, 5, 1'b1, -1);
        check("t5_idx", got_idx, 3); check("t5_x", got_x, 2); check("t5_y", got_y, 5);
        run(6, 8, 0, 0, 1'b0, -1);
        check("t6_idx", got_idx, 5); check("t6_x", got_x, 8);

        // Oversized count clamps to a full 1024-node scan
        for (int i = 0; i < 1024; i++) set_node(i, 1000 + (i % 7), -500);
        set_node(1023, 7, 7);
        run(2047, 7, 7, 0, 1'b0, -1);
        check("t7_lat", got_lat, 1027); check("t7_idx", got_idx, 1023);

        // Asynchronous reset in SCAN cycle 3 of an 8-node scan
        clear_mem();
        for (int i = 0; i < 8; i++) set_node(i, i, i);
        @(negedge clk);
        start_valid = 1'b1; query_x = '0; query_y = '0; node_count = 11'd8;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("pre_rst_addr", longint'(mem_address), 2);
        rst = 1'b1;
        #1;
        check("abort_valid", longint'(result_valid), 0);
        check("abort_found", longint'(result_found), 0);
        check("abort_index", longint'(result_index), 0);
        check("abort_xy", longint'({result_y, result_x}), 0);
        check("abort_addr", longint'(mem_address), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_start_ready", longint'(start_ready), 1);
        check("abort_valid_idle", longint'(result_valid), 0);
        clear_mem(); set_node(0, 5, 5); set_node(1, 1, 1); set_node(2, 1, 1);
        run(3, 0, 0, 0, 1'b0, -1);
        check("t8_lat", got_lat, 6); check("t8_idx", got_idx, 1);

`ifdef NN_SCAN_MAXDIST_EN
        clear_mem(); set_node(0, 3, 4); set_node(1, 6, 8);
        run(2, 0, 0, 0, 1'b0, 25);
        check("md25_found", got_found, 0); check("md25_idx", got_idx, 0);
        check("md25_x", got_x, 0);
        run(2, 0, 0, 0, 1'b0, 26);
        check("md26_found", got_found, 1); check("md26_idx", got_idx, 0);
        check("md26_x", got_x, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
